// File: rtl/mod5_pkg.sv
// Shared definitions for the mod-5 residue datapath: FSM encoding, residue
// constants and the MSB-first residue recurrence used by transmitter and checker.
package mod5_pkg;

    localparam int RES_W = 3;
    localparam int MOD5  = 5;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SHIFT   = 2'd1;
    localparam logic [1:0] ST_TRAILER = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // 2*r + b is at most 9 for r in 0..4, so one conditional subtract reduces it.
    function automatic logic [RES_W-1:0] mod5_step(input logic [RES_W-1:0] r, input logic b);
        logic [RES_W:0] t;
        t = {r, 1'b0} + {{RES_W{1'b0}}, b};
        if (t >= (RES_W+1)'(MOD5)) begin
            t = t - (RES_W+1)'(MOD5);
        end
        return t[RES_W-1:0];
    endfunction

endpackage

// File: rtl/mod5_residue_step.sv
// One step of the MSB-first mod-5 recurrence: next = (2*r + b) mod 5.
module mod5_residue_step
    import mod5_pkg::*;
(
    input  logic [RES_W-1:0] i_r,
    input  logic             i_b,
    output logic [RES_W-1:0] o_r
);

    assign o_r = mod5_step(i_r, i_b);

endmodule

// File: rtl/mod5_serial_tx.sv
// MSB-first parallel-to-serial transmitter with running mod-5 residue.
// Define MOD5_SERIAL_TX_TRAILER_EN to append the 3-bit residue after the data bits.
module mod5_serial_tx
    import mod5_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic             busy,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             done,
    output logic [RES_W-1:0] residue,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic [RES_W-1:0] r_residue;
    logic [RES_W-1:0] w_res_next;
`ifdef MOD5_SERIAL_TX_TRAILER_EN
    logic [1:0]       r_tcnt;
`endif

    mod5_residue_step u_step (
        .i_r (r_residue),
        .i_b (r_shift[WIDTH-1]),
        .o_r (w_res_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_residue <= '0;
`ifdef MOD5_SERIAL_TX_TRAILER_EN
            r_tcnt    <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_shift   <= data;
                        r_residue <= '0;
                        r_cnt     <= CNT_W'(WIDTH);
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_residue <= w_res_next;
                    r_shift   <= r_shift << 1;
                    r_cnt     <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
`ifdef MOD5_SERIAL_TX_TRAILER_EN
                        r_tcnt  <= 2'd2;
                        r_state <= ST_TRAILER;
`else
                        r_state <= ST_DONE;
`endif
                    end
                end
`ifdef MOD5_SERIAL_TX_TRAILER_EN
                // Residue stays frozen here; r_tcnt walks its bits 2 -> 0.
                ST_TRAILER: begin
                    if (r_tcnt == 2'd0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_tcnt <= r_tcnt - 1'b1;
                    end
                end
`endif
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; no input reaches an output combinationally.
    always_comb begin
        bit_out   = 1'b0;
        bit_valid = 1'b0;
        if (r_state == ST_SHIFT) begin
            bit_out   = r_shift[WIDTH-1];
            bit_valid = 1'b1;
        end
`ifdef MOD5_SERIAL_TX_TRAILER_EN
        if (r_state == ST_TRAILER) begin
            bit_out   = r_residue[r_tcnt];
            bit_valid = 1'b1;
        end
`endif
    end

    assign ready     = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_SHIFT) || (r_state == ST_TRAILER);
    assign done      = (r_state == ST_DONE);
    assign residue   = r_residue;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mod5_serial_tx.sv
// Directed bench for mod5_serial_tx at WIDTH=8 and WIDTH=10; follows
// MOD5_SERIAL_TX_TRAILER_EN to expect or skip the residue trailer.
module tb_mod5_serial_tx;
    import mod5_pkg::*;

`ifdef MOD5_SERIAL_TX_TRAILER_EN
    localparam int TRL = 3;
`else
    localparam int TRL = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load8 = 1'b0;
    logic [7:0] data8 = '0;
    logic       load10 = 1'b0;
    logic [9:0] data10 = '0;

    logic       ready8, busy8, bit8, valid8, done8;
    logic [2:0] res8;
    logic [1:0] st8;
    logic       ready10, busy10, bit10, valid10, done10;
    logic [2:0] res10;
    logic [1:0] st10;

    logic       sel10 = 1'b0;
    logic       o_ready, o_busy, o_bit, o_valid, o_done;
    logic [2:0] o_res;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mod5_serial_tx #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .load(load8), .data(data8),
        .ready(ready8), .busy(busy8), .bit_out(bit8), .bit_valid(valid8),
        .done(done8), .residue(res8), .dbg_state(st8)
    );

    mod5_serial_tx #(.WIDTH(10)) dut10 (
        .clk(clk), .reset(reset), .load(load10), .data(data10),
        .ready(ready10), .busy(busy10), .bit_out(bit10), .bit_valid(valid10),
        .done(done10), .residue(res10), .dbg_state(st10)
    );

    assign o_ready = sel10 ? ready10 : ready8;
    assign o_busy  = sel10 ? busy10  : busy8;
    assign o_bit   = sel10 ? bit10   : bit8;
    assign o_valid = sel10 ? valid10 : valid8;
    assign o_done  = sel10 ? done10  : done8;
    assign o_res   = sel10 ? res10   : res8;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference checker: integer form of the MSB-first residue recurrence.
    function automatic int chk_step(input int r, input logic b);
        return (2 * r + int'(b)) % 5;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, 32'(o_ready), 32'd1);
        check({tag, "_busy"},  32'(o_busy),  32'd0);
        check({tag, "_bit"},   32'(o_bit),   32'd0);
        check({tag, "_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_done"},  32'(o_done),  32'd0);
    endtask

    // Runs one full transfer on the selected DUT. inject pulses a load of 0xAA
    // on dut8 mid-stream; done_load raises load8 during the DONE cycle.
    task automatic xfer(input logic [31:0] d, input int w, input logic [2:0] exp_res,
                        input bit inject, input bit done_load);
        int fc;
        fc = 0;
        @(negedge clk);
        if (sel10) begin load10 = 1'b1; data10 = d[9:0]; end
        else       begin load8  = 1'b1; data8  = d[7:0]; end
        @(negedge clk);
        load8 = 1'b0;
        load10 = 1'b0;
        for (int i = 0; i < w; i++) begin
            if (i > 0) @(negedge clk);
            check("shift_busy",  32'(o_busy),  32'd1);
            check("shift_valid", 32'(o_valid), 32'd1);
            check("shift_ready", 32'(o_ready), 32'd0);
            check("data_bit",    32'(o_bit),   32'(d[w-1-i]));
            check("run_residue", 32'(o_res),   32'(fc));
            fc = chk_step(fc, o_bit);
            if (inject && i == 3) begin load8 = 1'b1; data8 = 8'hAA; end
            if (inject && i == 4) load8 = 1'b0;
        end
        for (int k = 0; k < TRL; k++) begin
            @(negedge clk);
            check("trl_valid",   32'(o_valid), 32'd1);
            check("trl_bit",     32'(o_bit),   32'(exp_res[2-k]));
            check("trl_residue", 32'(o_res),   32'(exp_res));
        end
        @(negedge clk);
        check("done_pulse",   32'(o_done),  32'd1);
        check("done_valid",   32'(o_valid), 32'd0);
        check("done_bit",     32'(o_bit),   32'd0);
        check("done_busy",    32'(o_busy),  32'd0);
        check("done_ready",   32'(o_ready), 32'd0);
        check("final_res",    32'(o_res),   32'(exp_res));
        check("checker_res",  32'(fc),      32'(exp_res));
        if (done_load) begin load8 = 1'b1; data8 = 8'hFF; end
        @(negedge clk);
        load8 = 1'b0;
        check_idle_outputs("post_done");
        check("hold_res", 32'(o_res), 32'(exp_res));
    endtask

    initial begin : main
        int done_seen;

        // Reset held low for two cycles, checked while low and after release.
        repeat (2) @(negedge clk);
        check_idle_outputs("rst_low");
        check("rst_res",   32'(o_res), 32'd0);
        check("rst_state", 32'(st8),   32'(ST_IDLE));
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("rst_rel");
        check("rst_rel_res", 32'(o_res), 32'd0);

        // 0x36 = 54, residue 4; a load during DONE must be ignored.
        xfer(32'h36, 8, 3'd4, 1'b0, 1'b1);
        @(negedge clk);
        check("done_load_ignored", 32'(o_busy), 32'd0);

        // 0x1F with a 0xAA load pulsed mid-transfer: residue 31 mod 5 = 1.
        xfer(32'h1F, 8, 3'd1, 1'b1, 1'b0);

        // 0xFF = 255, residue 0.
        xfer(32'hFF, 8, 3'd0, 1'b0, 1'b0);

        // Asynchronous reset after three data bits of 0x36.
        @(negedge clk);
        load8 = 1'b1;
        data8 = 8'h36;
        @(negedge clk);
        load8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_idle_outputs("mid_rst");
        check("mid_rst_res",   32'(o_res), 32'd0);
        check("mid_rst_state", 32'(st8),   32'(ST_IDLE));
        @(negedge clk);
        reset = 1'b1;
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (o_done) done_seen++;
        end
        check("no_done_after_rst", 32'(done_seen), 32'd0);
        xfer(32'h1F, 8, 3'd1, 1'b0, 1'b0);

        // WIDTH=10: 723 mod 5 = 3, 1 mod 5 = 1.
        sel10 = 1'b1;
        @(negedge clk);
        check_idle_outputs("w10_idle");
        xfer(32'd723, 10, 3'd3, 1'b0, 1'b0);
        xfer(32'd1, 10, 3'd1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
